fir_stim_src: RTL and testbench

Synthesizable stimulus source that streams a preloaded block of 11-bit samples into `myfir` over the DIN/VIN interface, with programmable inter-sample gaps. It raises END_SIM once the last sample has drained through the filter. It is the driving end of the FIR sample interface, complementing the output-side sink/checker. It replaces file-based data generation for on-chip or gate-level runs.

---
 rtl/fir_tb_pkg.sv | 18 +
 rtl/fir_stim_src_if.sv | 34 +++
 rtl/fir_stim_src_stim_mem.sv | 28 ++
 rtl/fir_stim_src.sv | 141 ++++++++++++++
 tb/tb_fir_stim_src.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/fir_tb_pkg.sv
// rtl/fir_tb_pkg.sv - shared types and defaults for the FIR stimulus source
// Purpose: state enum and default sizing shared by fir_stim_src and its bench.
// Ports: none (package).
package fir_tb_pkg;

    localparam int DW_DEF        = 11;
    localparam int AW_DEF        = 8;
    localparam int DRAIN_CYC_DEF = 12;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STREAM = 3'd1,
        ST_GAP    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } stim_state_e;

endpackage

// File: rtl/fir_stim_src_if.sv
// rtl/fir_stim_src_if.sv - control, sample-memory write and DIN/VIN bundle
// Purpose: groups every non-clock signal of fir_stim_src.
// Ports (source view, modport master):
//   i_wr_en/i_wr_addr/i_wr_data  sample memory write port
//   i_start/i_nsamp/i_gap        run request and its parameters
//   o_din/o_vin                  sample stream into the FIR
//   o_busy/o_end_sim/o_sent      run status
// Modport slave is the driving side (bench or system controller).
interface fir_stim_src_if #(
    parameter int DW = 11,
    parameter int AW = 8
);
    logic          i_wr_en;
    logic [AW-1:0] i_wr_addr;
    logic [DW-1:0] i_wr_data;
    logic          i_start;
    logic [AW:0]   i_nsamp;
    logic [3:0]    i_gap;
    logic [DW-1:0] o_din;
    logic          o_vin;
    logic          o_busy;
    logic          o_end_sim;
    logic [AW:0]   o_sent;

    modport master (
        input  i_wr_en, i_wr_addr, i_wr_data, i_start, i_nsamp, i_gap,
        output o_din, o_vin, o_busy, o_end_sim, o_sent
    );

    modport slave (
        output i_wr_en, i_wr_addr, i_wr_data, i_start, i_nsamp, i_gap,
        input  o_din, o_vin, o_busy, o_end_sim, o_sent
    );
endinterface

// File: rtl/fir_stim_src_stim_mem.sv
// rtl/fir_stim_src_stim_mem.sv - sample register file for the stimulus source
// Purpose: 2^AW x DW storage, one synchronous write port, one combinational
//          read port, no reset (contents survive reset).
// Ports:
//   i_clk                          write clock
//   i_wr_en/i_wr_addr/i_wr_data    write port
//   i_rd_addr/o_rd_data            combinational read port
module stim_mem #(
    parameter int DW = 11,
    parameter int AW = 8
) (
    input  logic          i_clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);
    logic [DW-1:0] r_mem [2**AW];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];
endmodule

// File: rtl/fir_stim_src.sv
// rtl/fir_stim_src.sv - streams preloaded samples into the FIR with gaps
// Purpose: on START, emits NSAMP samples from stim_mem on DIN/VIN with GAP idle
//          cycles between them, waits DRAIN_CYC more cycles, then holds END_SIM.
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   bus      fir_stim_src_if.master (memory write, run control, DIN/VIN, status)
module fir_stim_src
    import fir_tb_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int AW        = AW_DEF,
    parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    fir_stim_src_if.master bus
);
    localparam int DCW = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);

    stim_state_e    r_state;
    stim_state_e    w_next_state;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_remaining;
    logic [3:0]     r_gap_len;
    logic [3:0]     r_gap_cnt;
    logic [DCW-1:0] r_drain_cnt;
    logic [DW-1:0]  r_din;
    logic           r_vin;
    logic [AW:0]    r_sent;

    logic           w_idle_like;
    logic           w_accept;
    logic           w_mem_wr;
    logic [DW-1:0]  w_rd_data;

    assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_accept    = w_idle_like && bus.i_start && (bus.i_nsamp != '0);
    // Memory is frozen while a run is in flight.
    assign w_mem_wr    = w_idle_like && bus.i_wr_en;

    stim_mem #(
        .DW (DW),
        .AW (AW)
    ) u_mem (
        .i_clk     (i_clk),
        .i_wr_en   (w_mem_wr),
        .i_wr_addr (bus.i_wr_addr),
        .i_wr_data (bus.i_wr_data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    w_next_state = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (r_remaining == {{AW{1'b0}}, 1'b1}) begin
                    w_next_state = ST_DRAIN;
                end else if (r_gap_len != 4'd0) begin
                    w_next_state = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == 4'd0) begin
                    w_next_state = ST_STREAM;
                end
            end
            ST_DRAIN: begin
                if (r_drain_cnt == '0) begin
                    w_next_state = ST_DONE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Counters load on the STREAM cycle that precedes GAP/DRAIN so that GAP
    // lasts gap_len cycles and DRAIN ends DRAIN_CYC cycles after VIN falls
    // (the DRAIN cycle carrying the last VIN is not counted).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr    <= '0;
            r_remaining <= '0;
            r_gap_len   <= '0;
            r_gap_cnt   <= '0;
            r_drain_cnt <= '0;
            r_din       <= '0;
            r_vin       <= 1'b0;
            r_sent      <= '0;
        end else begin
            r_vin <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_rd_ptr    <= '0;
                        r_remaining <= bus.i_nsamp;
                        r_gap_len   <= bus.i_gap;
                        r_sent      <= '0;
                    end
                end
                ST_STREAM: begin
                    r_din       <= w_rd_data;
                    r_vin       <= 1'b1;
                    r_rd_ptr    <= r_rd_ptr + 1'b1;
                    r_sent      <= r_sent + 1'b1;
                    r_remaining <= r_remaining - 1'b1;
                    r_gap_cnt   <= r_gap_len - 4'd1;
                    r_drain_cnt <= DCW'(DRAIN_CYC);
                end
                ST_GAP: begin
                    r_gap_cnt <= r_gap_cnt - 4'd1;
                end
                ST_DRAIN: begin
                    r_drain_cnt <= r_drain_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_din     = r_din;
    assign bus.o_vin     = r_vin;
    assign bus.o_sent    = r_sent;
    assign bus.o_end_sim = (r_state == ST_DONE);
    assign bus.o_busy    = (r_state == ST_STREAM) || (r_state == ST_GAP) ||
                           (r_state == ST_DRAIN);
endmodule

// File: tb/tb_fir_stim_src.sv
// tb/tb_fir_stim_src.sv - scoreboard bench for fir_stim_src
module tb_fir_stim_src;
    import fir_tb_pkg::*;

    localparam int DW = 11;
    localparam int AW = 8;
    localparam int D  = 12;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fir_stim_src_if #(.DW(DW), .AW(AW)) bus ();

    fir_stim_src #(.DW(DW), .AW(AW), .DRAIN_CYC(D)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] mdl_mem [256];
    logic [DW-1:0] exp_q [$];
    int            vin_cyc [$];
    int            n_popped = 0;
    logic [DW-1:0] last_din = '0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every VIN pulse pops one expected sample; DIN must hold otherwise.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_din = '0;
        end else if (bus.o_vin) begin
            vin_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_vin", int'(bus.o_vin), 0);
            end else begin
                chk("din", int'(bus.o_din), int'(exp_q.pop_front()));
                n_popped++;
            end
            last_din = bus.o_din;
        end else begin
            chk("din_hold", int'(bus.o_din), int'(last_din));
        end
    end

    task automatic wr(input int a, input int d, input bit upd_model);
        bus.i_wr_en   = 1'b1;
        bus.i_wr_addr = AW'(a);
        bus.i_wr_data = DW'(d);
        if (upd_model) mdl_mem[a] = DW'(d);
        @(posedge clk); #1;
        bus.i_wr_en = 1'b0;
    endtask

    task automatic start_run(input int n, input int g, output int k);
        for (int i = 0; i < n; i++) exp_q.push_back(mdl_mem[i % 256]);
        vin_cyc.delete();
        n_popped      = 0;
        bus.i_start   = 1'b1;
        bus.i_nsamp   = (AW+1)'(n);
        bus.i_gap     = 4'(g);
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        k = cyc;
    endtask

    task automatic wait_done(input int k, input int n, input int g);
        bit seen = 0;
        for (int i = 0; i < 4000 && !seen; i++) begin
            @(negedge clk);
            if (bus.o_end_sim) seen = 1;
        end
        chk("end_sim_timeout", int'(bus.o_end_sim), 1);
        chk("run_cycles", cyc - k, 1 + n + (n - 1) * g + D);
        chk("sent", int'(bus.o_sent), n);
        chk("busy_at_done", int'(bus.o_busy), 0);
        chk("samples_left", exp_q.size(), 0);
        chk("vin_count", vin_cyc.size(), n);
        if (vin_cyc.size() == n) begin
            chk("first_vin_latency", vin_cyc[0] - k, 1);
            for (int i = 1; i < n; i++) chk("vin_spacing", vin_cyc[i] - vin_cyc[i-1], g + 1);
            chk("drain_after_last_vin", cyc - vin_cyc[n-1], D + 1);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int k;
        bit hit;
        bus.i_wr_en = 0; bus.i_wr_addr = '0; bus.i_wr_data = '0;
        bus.i_start = 0; bus.i_nsamp = '0;   bus.i_gap = '0;
        for (int i = 0; i < 256; i++) mdl_mem[i] = '0;

        repeat (3) @(posedge clk); #1;
        chk("rst_vin", int'(bus.o_vin), 0);
        chk("rst_din", int'(bus.o_din), 0);
        chk("rst_busy", int'(bus.o_busy), 0);
        chk("rst_end_sim", int'(bus.o_end_sim), 0);
        chk("rst_sent", int'(bus.o_sent), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // NSAMP=0 from IDLE is ignored.
        bus.i_start = 1'b1; bus.i_nsamp = '0;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("nsamp0_idle_busy", int'(bus.o_busy), 0);

        // Directed samples: 1, -1, 1023, -1024, 0.
        wr(0, 11'h001, 1); wr(1, 11'h7FF, 1); wr(2, 11'h3FF, 1);
        wr(3, 11'h400, 1); wr(4, 11'h000, 1);

        start_run(5, 0, k);
        wait_done(k, 5, 0);

        start_run(3, 2, k);
        wait_done(k, 3, 2);

        // NSAMP=0 from DONE is ignored.
        bus.i_start = 1'b1; bus.i_nsamp = '0;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        chk("nsamp0_done_end_sim", int'(bus.o_end_sim), 1);
        chk("nsamp0_done_busy", int'(bus.o_busy), 0);

        // Restart from DONE.
        start_run(2, 0, k);
        chk("restart_end_sim", int'(bus.o_end_sim), 0);
        chk("restart_sent", int'(bus.o_sent), 0);
        chk("restart_busy", int'(bus.o_busy), 1);
        wait_done(k, 2, 0);

        // START and writes while busy are dropped; latched NSAMP/GAP hold.
        start_run(4, 3, k);
        bus.i_start = 1'b1; bus.i_nsamp = 9'd7; bus.i_gap = 4'd0;
        wr(2, 11'h155, 0);
        bus.i_start = 1'b0;
        repeat (2) @(posedge clk); #1;
        wr(3, 11'h2AA, 0);
        chk("busy_during_run", int'(bus.o_busy), 1);
        wait_done(k, 4, 3);

        // Full depth, no wrap repeat.
        for (int i = 0; i < 256; i++) wr(i, (i * 37 + 5) & 11'h7FF, 1);
        start_run(256, 0, k);
        wait_done(k, 256, 0);

        // Reset mid-run at sample 3.
        start_run(5, 1, k);
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (n_popped >= 3) hit = 1;
        end
        chk("reach_sample3", n_popped, 3);
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        chk("midrst_vin", int'(bus.o_vin), 0);
        chk("midrst_din", int'(bus.o_din), 0);
        chk("midrst_end_sim", int'(bus.o_end_sim), 0);
        chk("midrst_sent", int'(bus.o_sent), 0);
        chk("midrst_busy", int'(bus.o_busy), 0);
        rst_n = 1'b1;
        repeat (30) @(posedge clk); #1;
        chk("no_vin_after_reset", vin_cyc.size(), 3);
        chk("idle_after_reset", int'(bus.o_busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
